mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares one single-ported memory bus between the IF-stage instruction fetch port and the MEM-stage data port.
// - Generates the imem_wait / dmem_wait stall signals consumed by the hazard unit (pipe_enable gating).
// - Data port has priority; a starvation counter bounds the number of back-to-back data grants while a fetch is pending.
// - Watchdog terminates a bus transaction that is never acknowledged.
// PARAMETERS
// - ADDR_WIDTH     32   byte address width, both ports and bus
// - DATA_WIDTH     32   data width; byte enables are DATA_WIDTH/8 bits
// - STARVE_LIMIT   4    max consecutive data grants while imem_req is pending; range 1..15
// - TIMEOUT        255  cycles in BUSY without bus_ack before forced completion; range 1..255, counter is 8 bits
// PORTS
// - clk          in   1       single clock, all state updates on its rising edge
// - reset        in   1       synchronous, active-high
// - imem_req     in   1       fetch request, level; held until imem_wait is low
// - imem_addr    in   AW      fetch address
// - imem_rdata   out  DW      fetch data; valid only in the cycle imem_wait is low with imem_req high
// - imem_wait    out  1       imem_req && !(fetch completes this cycle)
// - dmem_req     in   1       load/store request, level
// - dmem_we      in   1       1 = store
// - dmem_be      in   DW/8    store byte enables
// - dmem_addr    in   AW      data address
// - dmem_wdata   in   DW      store data
// - dmem_rdata   out  DW      load data; valid only in the cycle dmem_wait is low
// - dmem_wait    out  1       dmem_req && !(data access completes this cycle)
// - bus_req      out  1       registered; held high from grant until bus_ack or timeout
// - bus_we / bus_be / bus_addr / bus_wdata  out  1/DW8/AW/DW  registered at grant, stable while bus_req
// - bus_ack      in   1       one-cycle completion strobe; ignored when bus_req is low
// - bus_rdata    in   DW      valid with bus_ack
// - bus_error    out  1       one-cycle pulse on watchdog expiry
// BEHAVIOUR
// - States: IDLE, BUSY_I, BUSY_D. Reset -> IDLE. Reset values: bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0,
//   bus_error=0, starve_cnt=0, wd_cnt=0. imem_wait and dmem_wait equal the raw req inputs while in IDLE.
// - IDLE: if dmem_req && !(imem_req && starve_cnt==STARVE_LIMIT) -> BUSY_D; else if imem_req -> BUSY_I.
//   Bus outputs are latched from the granted port on the transition edge. Minimum latency is 2 cycles (grant edge, then ack).
// - BUSY_x: when bus_ack=1, the x port's wait goes low combinationally and its rdata = bus_rdata (stores return rdata=0).
//   bus_req drops on the next edge and the state returns to IDLE. Back-to-back transactions therefore have one IDLE cycle between them.
// - starve_cnt: increments on each BUSY_D grant while imem_req=1 (saturating at STARVE_LIMIT).
//   Clears on any BUSY_I grant or when imem_req=0 in IDLE.
// - Watchdog: wd_cnt clears on grant and increments each BUSY cycle without ack. On reaching TIMEOUT, act as if bus_ack had arrived
//   with rdata=0, pulse bus_error for 1 cycle, and return to IDLE.
// - Request withdrawn mid-transaction (e.g. fetch squashed by a taken branch): the bus transaction still runs to ack.
//   The result is discarded, the wait output follows the dropped req (low), and no completion is reported to a later request.
// - Request address change mid-transaction: ignored. The bus keeps the latched address; the requester must hold stable.
// - Simultaneous ack and a new request in the same cycle: the new request is arbitrated only from IDLE on the next cycle.
// - bus_ack in IDLE: ignored.
// - Reset asserted mid-transaction: the FSM returns to IDLE and bus_req drops on that edge. A late bus_ack is ignored.
// STRUCTURE
// - Shared types package gets: enum arb_state_t {IDLE, BUSY_I, BUSY_D} and owner_t {OWN_NONE, OWN_I, OWN_D}.
// - Sub-module mem_arb_fairness: starve_cnt counter plus the "force fetch grant" decision, parameterised by STARVE_LIMIT.
// - FSM, bus output registers and watchdog stay in mem_arbiter; wait/rdata steering is combinational in the same file.
// TESTING
// - Fetch only: imem_req=1 at 0x100, bus_ack 3 cycles after bus_req -> imem_wait low on the ack cycle,
//   imem_rdata=bus_rdata, bus_req low next cycle.
// - Simultaneous imem_req and dmem_req (store 0xDEADBEEF, be=4'hF, addr 0x2000) -> data granted first with bus_we=1 and
//   imem_wait held 1; fetch granted next.
// - Continuous dmem_req and imem_req, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,...; starve_cnt returns to 0 after the I grant.
// - Fetch withdrawn in BUSY_I before ack -> bus_req stays 1 until ack, imem_wait=0, no stale rdata delivered to the next fetch.
// - No bus_ack, TIMEOUT=8 -> bus_error pulses 8 BUSY cycles after grant, requester wait drops with rdata=0, FSM returns to IDLE.
// - reset=1 in BUSY_D -> next edge: bus_req=0, state IDLE; a bus_ack in the following cycle causes no completion.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared types for the memory bus arbiter slice.
//   arb_state_t : arbiter FSM states (idle, fetch owns bus, data owns bus)
//   owner_t     : which port currently owns the bus transaction
//   state_owner : maps an FSM state to the port that owns the bus
// ----------------------------------------------------------------------------
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Starvation counter covers STARVE_LIMIT up to 15, watchdog up to 255.
    localparam int STARVE_CNT_W = 4;
    localparam int WD_CNT_W     = 8;

    function automatic owner_t state_owner(input arb_state_t s);
        owner_t o;
        case (s)
            BUSY_I:  o = OWN_I;
            BUSY_D:  o = OWN_D;
            default: o = OWN_NONE;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/mem_arb_fairness.sv
// ----------------------------------------------------------------------------
// mem_arb_fairness
// Tracks how many data grants have been issued back-to-back while a fetch was
// waiting, and tells the arbiter when the fetch must be served next.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   imem_req      : fetch request level
//   in_idle       : arbiter is in IDLE this cycle
//   grant_d       : data port is being granted on this edge
//   grant_i       : fetch port is being granted on this edge
//   force_fetch   : fetch is pending and has been starved STARVE_LIMIT times
//   starve_cnt    : current count of consecutive data grants over a pending fetch
// ----------------------------------------------------------------------------
module mem_arb_fairness
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    imem_req,
    input  logic                    in_idle,
    input  logic                    grant_d,
    input  logic                    grant_i,
    output logic                    force_fetch,
    output logic [STARVE_CNT_W-1:0] starve_cnt
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    assign force_fetch = imem_req && (starve_cnt == LIMIT);

    // A data grant only counts as starvation when a fetch is actually waiting;
    // an idle cycle with no fetch pending means nobody is being starved.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (grant_i) begin
            starve_cnt <= '0;
        end else if (grant_d && imem_req && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end else if (in_idle && !imem_req) begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-ported memory bus between the instruction fetch port and
// the data port. Data has priority, bounded by the fairness counter. A
// watchdog forces completion of a transaction that is never acknowledged.
// Ports:
//   clk, reset                    : clock and synchronous active-high reset
//   imem_req/addr/rdata/wait      : fetch port
//   dmem_req/we/be/addr/wdata     : data port request side
//   dmem_rdata/wait               : data port response side
//   bus_req/we/be/addr/wdata      : registered bus request, stable while bus_req
//   bus_ack/bus_rdata             : bus completion strobe and read data
//   bus_error                     : one-cycle pulse when the watchdog fires
// ----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    imem_req,
    input  logic [ADDR_WIDTH-1:0]   imem_addr,
    output logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic                    imem_wait,
    input  logic                    dmem_req,
    input  logic                    dmem_we,
    input  logic [DATA_WIDTH/8-1:0] dmem_be,
    input  logic [ADDR_WIDTH-1:0]   dmem_addr,
    input  logic [DATA_WIDTH-1:0]   dmem_wdata,
    output logic [DATA_WIDTH-1:0]   dmem_rdata,
    output logic                    dmem_wait,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [DATA_WIDTH/8-1:0] bus_be,
    output logic [ADDR_WIDTH-1:0]   bus_addr,
    output logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic                    bus_ack,
    input  logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    bus_error
);

    // The watchdog fires in the TIMEOUT-th busy cycle, so compare against one less.
    localparam logic [WD_CNT_W-1:0] WD_LAST = WD_CNT_W'(TIMEOUT - 1);

    arb_state_t              state;
    logic [WD_CNT_W-1:0]     wd_cnt;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic                    force_fetch;
    logic                    in_idle;
    logic                    busy;
    logic                    grant_d;
    logic                    grant_i;
    logic                    wd_expire;
    logic                    done;
    logic                    done_i;
    logic                    done_d;
    logic [DATA_WIDTH-1:0]   rdata_done;
    owner_t                  owner;

    assign in_idle = (state == IDLE);
    assign busy    = !in_idle;
    assign owner   = state_owner(state);

    assign grant_d = in_idle && dmem_req && !force_fetch;
    assign grant_i = in_idle && imem_req && !grant_d;

    // A real ack in the expiry cycle wins, so the watchdog never reports an
    // error for a transaction that did complete.
    assign wd_expire  = busy && !bus_ack && (wd_cnt == WD_LAST);
    assign done       = busy && (bus_ack || wd_expire);
    assign done_i     = done && (owner == OWN_I);
    assign done_d     = done && (owner == OWN_D);
    assign rdata_done = wd_expire ? '0 : bus_rdata;

    // Completion is only reported to a requester that is still asking; a
    // squashed request sees its wait follow the dropped req and gets no data.
    assign imem_wait  = imem_req && !done_i;
    assign dmem_wait  = dmem_req && !done_d;
    assign imem_rdata = (imem_req && done_i) ? rdata_done : '0;
    assign dmem_rdata = (dmem_req && done_d && !bus_we) ? rdata_done : '0;

    mem_arb_fairness #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_fairness (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .in_idle     (in_idle),
        .grant_d     (grant_d),
        .grant_i     (grant_i),
        .force_fetch (force_fetch),
        .starve_cnt  (starve_cnt)
    );

    // FSM, bus request registers and watchdog. Bus fields are captured from
    // the granted port on the grant edge and held until completion, so later
    // address changes from the requester have no effect on the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_error <= 1'b0;
            wd_cnt    <= '0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (grant_d) begin
                        state     <= BUSY_D;
                        bus_req   <= 1'b1;
                        bus_we    <= dmem_we;
                        bus_be    <= dmem_be;
                        bus_addr  <= dmem_addr;
                        bus_wdata <= dmem_wdata;
                    end else if (grant_i) begin
                        state     <= BUSY_I;
                        bus_req   <= 1'b1;
                        bus_we    <= 1'b0;
                        bus_be    <= '1;
                        bus_addr  <= imem_addr;
                        bus_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state     <= IDLE;
                        bus_req   <= 1'b0;
                        bus_error <= wd_expire;
                        wd_cnt    <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                    wd_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter: fetch-only, data priority, starvation bound,
// squashed fetch, watchdog expiry and reset during a data transaction.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_wait;
    logic        dmem_req;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_error;

    int testCount = 0;
    int failCount = 0;

    mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .STARVE_LIMIT (4),
        .TIMEOUT      (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_wait  (imem_wait),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_be    (dmem_be),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_wait  (dmem_wait),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_be     (bus_be),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
        .bus_error  (bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every DUT input, then let combinational outputs settle.
    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata,
                                 input logic ack, input logic [31:0] rdata);
        imem_req   = ireq;
        imem_addr  = iaddr;
        dmem_req   = dreq;
        dmem_we    = dwe;
        dmem_be    = dbe;
        dmem_addr  = daddr;
        dmem_wdata = dwdata;
        bus_ack    = ack;
        bus_rdata  = rdata;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] grantAddr [6];
        logic [31:0] grantCnt  [6];
        grantAddr = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h100, 32'h3000};
        grantCnt  = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd0, 32'd1};

        // Reset and idle values
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        #2;
        checkOutput("rst_bus_req",   32'(bus_req),   32'd0);
        checkOutput("rst_bus_addr",  bus_addr,       32'd0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
        checkOutput("rst_starve",    32'(dut.u_fairness.starve_cnt), 32'd0);
        checkOutput("rst_dwait",     32'(dmem_wait), 32'd0);

        // Fetch only, ack three cycles after bus_req rises
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f_idle_iwait", 32'(imem_wait), 32'd1);
        tick();
        checkOutput("f_bus_req",  32'(bus_req),   32'd1);
        checkOutput("f_bus_addr", bus_addr,       32'h100);
        checkOutput("f_bus_we",   32'(bus_we),    32'd0);
        checkOutput("f_iwait_b1", 32'(imem_wait), 32'd1);
        tick();
        tick();
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D);
        checkOutput("f_iwait_ack",  32'(imem_wait), 32'd0);
        checkOutput("f_irdata_ack", imem_rdata,     32'hCAFEF00D);
        checkOutput("f_bus_req_ack", 32'(bus_req),  32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("f_bus_req_after", 32'(bus_req), 32'd0);

        // Simultaneous fetch and store: data goes first
        applyStimulus(1, 32'h100, 1, 1, 4'hF, 32'h2000, 32'hDEADBEEF, 0, 0);
        checkOutput("s_idle_dwait", 32'(dmem_wait), 32'd1);
        tick();
        checkOutput("s_bus_we",    32'(bus_we),    32'd1);
        checkOutput("s_bus_addr",  bus_addr,       32'h2000);
        checkOutput("s_bus_wdata", bus_wdata,      32'hDEADBEEF);
        checkOutput("s_bus_be",    32'(bus_be),    32'hF);
        checkOutput("s_iwait",     32'(imem_wait), 32'd1);
        checkOutput("s_starve1",   32'(dut.u_fairness.starve_cnt), 32'd1);
        applyStimulus(1, 32'h100, 1, 1, 4'hF, 32'h2000, 32'hDEADBEEF, 1, 32'h12345678);
        checkOutput("s_dwait_ack",  32'(dmem_wait), 32'd0);
        checkOutput("s_drdata_st",  dmem_rdata,     32'd0);
        checkOutput("s_iwait_ack",  32'(imem_wait), 32'd1);
        tick();
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("s_idle_bus_req", 32'(bus_req), 32'd0);
        tick();
        checkOutput("s_i_bus_addr", bus_addr, 32'h100);
        checkOutput("s_i_starve0",  32'(dut.u_fairness.starve_cnt), 32'd0);
        applyStimulus(1, 32'h100, 0, 0, 0, 0, 0, 1, 32'h11111111);
        checkOutput("s_i_rdata", imem_rdata, 32'h11111111);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Continuous fetch and load: D,D,D,D,I,D
        applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h3000, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            tick();
            checkOutput($sformatf("st_addr%0d", k), bus_addr, grantAddr[k]);
            checkOutput($sformatf("st_cnt%0d", k), 32'(dut.u_fairness.starve_cnt), grantCnt[k]);
            applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h3000, 0, 1, 32'hA0 + 32'(k));
            if (grantAddr[k] == 32'h3000)
                checkOutput($sformatf("st_drdata%0d", k), dmem_rdata, 32'hA0 + 32'(k));
            else
                checkOutput($sformatf("st_irdata%0d", k), imem_rdata, 32'hA0 + 32'(k));
            tick();
            applyStimulus(1, 32'h100, 1, 0, 4'hF, 32'h3000, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Fetch squashed before ack
        applyStimulus(1, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 32'h400, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sq_iwait",   32'(imem_wait), 32'd0);
        checkOutput("sq_bus_req", 32'(bus_req),   32'd1);
        tick();
        checkOutput("sq_bus_req2", 32'(bus_req), 32'd1);
        applyStimulus(0, 32'h400, 0, 0, 0, 0, 0, 1, 32'hBAD0BAD0);
        checkOutput("sq_irdata_ack", imem_rdata, 32'd0);
        tick();
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("sq_new_iwait",  32'(imem_wait), 32'd1);
        checkOutput("sq_new_irdata", imem_rdata,     32'd0);
        tick();
        checkOutput("sq_new_addr", bus_addr, 32'h500);
        applyStimulus(1, 32'h500, 0, 0, 0, 0, 0, 1, 32'h55555555);
        checkOutput("sq_new_rdata", imem_rdata, 32'h55555555);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Watchdog: no ack, TIMEOUT = 8
        applyStimulus(0, 0, 1, 0, 4'hF, 32'h6000, 0, 0, 32'hFFFFFFFF);
        tick();
        for (int c = 1; c < 8; c++) begin
            checkOutput($sformatf("wd_dwait%0d", c), 32'(dmem_wait), 32'd1);
            checkOutput($sformatf("wd_err%0d", c),   32'(bus_error), 32'd0);
            tick();
        end
        checkOutput("wd_dwait_exp",  32'(dmem_wait), 32'd0);
        checkOutput("wd_drdata_exp", dmem_rdata,     32'd0);
        checkOutput("wd_bus_req_exp", 32'(bus_req),  32'd1);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wd_err_pulse", 32'(bus_error), 32'd1);
        checkOutput("wd_bus_req",   32'(bus_req),   32'd0);
        checkOutput("wd_state",     32'(dut.state), 32'(IDLE));
        tick();
        checkOutput("wd_err_clear", 32'(bus_error), 32'd0);

        // Reset during a data transaction, then a late ack
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h7000, 32'h0BADF00D, 0, 0);
        tick();
        checkOutput("r_bus_req_busy", 32'(bus_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(0, 0, 1, 1, 4'h3, 32'h7000, 32'h0BADF00D, 1, 32'hAAAAAAAA);
        checkOutput("r_bus_req", 32'(bus_req),   32'd0);
        checkOutput("r_state",   32'(dut.state), 32'(IDLE));
        checkOutput("r_late_ack_dwait", 32'(dmem_wait), 32'd1);
        checkOutput("r_late_ack_rdata", dmem_rdata,     32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

    // Safety net so the bench can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL timeout: observed no finish expected finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
